sha256_block_feeder: RTL

- Upstream stage of the SHA-256 compression core.
- On start, reads NUM_OF_WORDS 32-bit message words from the shared word-addressed memory starting at input_addr.
- Applies SHA-256 padding: a 0x80000000 word, zero fill, then a 64-bit bit-length.
- Streams the resulting 512-bit blocks to the round logic one 32-bit word per valid/ready handshake, tagged with word and block indices.

---
 rtl/sha256_pkg.sv | 38 +++
 rtl/sha256_skid_fifo.sv | 50 +++++
 rtl/sha256_block_feeder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and helpers for the SHA-256 message feeder and compression core.
package sha256_pkg;

  localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPad,
    StDone
  } feeder_state_e;

  // One streamed word together with its position tags.
  typedef struct packed {
    logic [31:0] word;
    logic [3:0]  word_idx;
    logic [7:0]  block_idx;
    logic        last;
  } feed_entry_t;

  // Blocks needed for n message words plus the 0x80000000 word and 64-bit length.
  function automatic int unsigned num_blocks(input int unsigned n);
    return (n + 2) / 16 + 1;
  endfunction

  // Padding-region word g for an n-word message in a stream of total words.
  function automatic logic [31:0] pad_word(input logic [31:0] g, input logic [31:0] n,
                                           input logic [31:0] total);
    if (g == n) begin
      return SHA256_PAD_WORD;
    end else if (g == total - 32'd1) begin
      return n << 5;
    end else begin
      return 32'h0;
    end
  endfunction

endpackage

// File: rtl/sha256_skid_fifo.sv
// Two-entry FIFO of tagged words; head is visible combinationally, count tracks occupancy.
module sha256_skid_fifo
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  feed_entry_t push_data_i,
  input  logic        pop_i,
  output feed_entry_t head_o,
  output logic [1:0]  count_o
);

  feed_entry_t mem_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop;

  // Push is allowed into a full FIFO only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sha256_block_feeder.sv
// Reads an N-word message from memory, appends SHA-256 padding and length, and streams the
// padded 512-bit blocks one tagged word per valid/ready handshake.
module sha256_block_feeder
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_OF_WORDS = 20,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] input_addr,
  output logic [ADDR_W-1:0] memory_addr,
  input  logic [31:0]       memory_read_data,
  output logic [31:0]       word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [3:0]        word_index,
  output logic [7:0]        block_index,
  output logic              last_block,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NumBlocks = num_blocks(NUM_OF_WORDS);
  localparam int unsigned Total     = NumBlocks * 16;
  localparam logic [31:0] NumWords  = 32'(NUM_OF_WORDS);
  localparam logic [31:0] TotalW    = 32'(Total);
  localparam logic [31:0] LastBlk   = 32'(NumBlocks - 1);

  feeder_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;    // memory reads issued
  logic [31:0]       wr_cnt_q, wr_cnt_d;    // words pushed into the FIFO (stream index g)
  logic [31:0]       out_cnt_q, out_cnt_d;  // words handed to the consumer
  logic              inflight_q, inflight_d;

  logic [1:0]        fifo_count;
  feed_entry_t       fifo_head;
  feed_entry_t       push_data;
  logic              push, pop, issue;
  logic [31:0]       push_word;

  // Handshake and read-issue decisions; a read is only issued if its data is sure to fit.
  always_comb begin
    pop   = (fifo_count != 2'd0) && word_ready;
    issue = (state_q == StFetch) && (rd_cnt_q < NumWords) &&
            (({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
  end

  // Select the FIFO write source: returned memory data in FETCH, generated padding in PAD.
  always_comb begin
    push      = 1'b0;
    push_word = 32'h0;
    case (state_q)
      StFetch: begin
        push      = inflight_q;
        push_word = memory_read_data;
      end
      StPad: begin
        push      = (wr_cnt_q < TotalW) && ({1'b0, fifo_count} < (3'd2 + {2'b0, pop}));
        push_word = pad_word(wr_cnt_q, NumWords, TotalW);
      end
      default: ;
    endcase
    push_data.word      = push_word;
    push_data.word_idx  = wr_cnt_q[3:0];
    push_data.block_idx = wr_cnt_q[11:4];
    push_data.last      = ((wr_cnt_q >> 4) == LastBlk);
  end

  // Next-state logic for the control FSM and its counters.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rd_cnt_d   = rd_cnt_q + 32'(issue);
    wr_cnt_d   = wr_cnt_q + 32'(push);
    out_cnt_d  = out_cnt_q + 32'(pop);
    inflight_d = issue;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFetch;
          base_d    = input_addr;
          rd_cnt_d  = 32'h0;
          wr_cnt_d  = 32'h0;
          out_cnt_d = 32'h0;
        end
      end
      // The cycle that sees all reads issued is the one pushing the last returned word.
      StFetch: begin
        if (rd_cnt_q == NumWords) begin
          state_d = StPad;
        end
      end
      StPad: begin
        if (pop && (out_cnt_q == TotalW - 32'd1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      rd_cnt_q   <= 32'h0;
      wr_cnt_q   <= 32'h0;
      out_cnt_q  <= 32'h0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  sha256_skid_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // Outputs: stream fields are zeroed whenever the FIFO is empty.
  always_comb begin
    word_valid  = (fifo_count != 2'd0);
    word_out    = word_valid ? fifo_head.word : 32'h0;
    word_index  = word_valid ? fifo_head.word_idx : 4'h0;
    block_index = word_valid ? fifo_head.block_idx : 8'h0;
    last_block  = word_valid && fifo_head.last;
    memory_addr = (state_q == StFetch) ? (base_q + rd_cnt_q[ADDR_W-1:0]) : '0;
    busy        = (state_q == StFetch) || (state_q == StPad);
    done        = (state_q == StDone);
  end

endmodule
